matrix_wb_arbiter: RTL and testbench
====================================

Name: matrix_wb_arbiter

Overview:
Writeback arbiter for the tensor-core matrix register file. It sits directly upstream of the matrix register status table.
- Collects completion notices (destination matrix register, producing FU) from up to NUM_FU matrix functional units (load/store, GEMM, ...).
- Buffers them per FU and grants one per cycle, round-robin.
- Drives the status table's writeback inputs (wb_sel, wb_write) plus the producer tag.

Parameters:
NUM_FU, 3, number of completing functional units; legal 1..3 because tag 0 is reserved and tags are 2 bits.
DEPTH, 2, entries per per-FU completion FIFO; power of two, >=1.
REG_W, 6, matrix register select width; matches status-table wb_sel.

Ports:
CLK  input  1  clock, all state updates on rising edge.
nRST  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline flush; drops all pending completions.
fu_valid  input  NUM_FU  per-FU completion request.
fu_rd  input  NUM_FU*REG_W  per-FU destination register; FU i occupies bits [i*REG_W +: REG_W].
fu_ready  output  NUM_FU  per-FU FIFO can accept this cycle.
wb_write  output  1  writeback strobe to status table.
wb_sel  output  REG_W  register being written back.
wb_tag  output  2  producing FU tag = FU index + 1.
pending  output  NUM_FU*($clog2(DEPTH)+1)  per-FU FIFO occupancy, for debug and perf counters.

Behaviour:
- Reset (nRST=0, async):
  - all FIFOs empty; rr_ptr=0.
  - wb_write=0, wb_sel=0, wb_tag=0, pending=0.
  - fu_ready=all ones after reset deasserts (combinational from occupancy).
- Handshake:
  - fu_ready[i] = (occupancy[i] != DEPTH) && !flush.
  - It depends only on registered occupancy and flush, never on the same-cycle grant. A full FIFO that is being drained still shows ready=0.
  - Enqueue on an edge where fu_valid[i] && fu_ready[i].
- Arbitration (combinational, each cycle):
  - Candidates are the non-empty FIFOs.
  - Search starts at rr_ptr and goes in increasing index, wrapping modulo NUM_FU; the first candidate wins. At most one grant per cycle.
  - On a grant to i: pop head of FIFO i; rr_ptr <= (i+1) mod NUM_FU.
  - No grant: rr_ptr holds.
- Output register:
  - On a grant, on the next edge: wb_write<=1, wb_sel<=head rd, wb_tag<=i+1.
  - Otherwise wb_write<=0; wb_sel and wb_tag hold their last values.
  - The status table always accepts writebacks, so there is no downstream backpressure.
- Latency: fu_valid accepted in cycle 0 -> wb_write=1 in cycle 2 when uncontended.
  - Sustained throughput is 1 writeback per cycle aggregate.
  - With a single active FU: 1/cycle when DEPTH>=2; 1 per 2 cycles when DEPTH=1, because ready is occupancy-based.
- Simultaneous enqueue and dequeue on the same FIFO in one cycle is legal; occupancy is unchanged.
- Ordering:
  - Per-FU order is strictly FIFO.
  - No ordering guarantee across FUs, beyond round-robin fairness: a continuously non-empty FU waits at most NUM_FU-1 cycles for a grant.
- Same rd from two FUs: both writebacks are emitted, in grant order, with distinct tags. The status table resolves them by tag.
- Flush (synchronous, priority over everything except reset):
  - On the edge with flush=1: all FIFOs cleared, rr_ptr<=0, wb_write<=0.
  - Inputs in the flush cycle are dropped (fu_ready=0).
  - A grant computed in the flush cycle is discarded.
- Reset mid-operation: all pending entries are lost immediately and outputs go to reset values asynchronously. No partial writeback is emitted.
- Occupancy counters never exceed DEPTH and never underflow. Assertions are required in the bench.

Test Plan:
- Reset then a single completion: fu_valid[0]=1, fu_rd[0]=6'd12 in cycle 0 -> cycle 2 shows wb_write=1, wb_sel=12, wb_tag=1; cycle 3 shows wb_write=0, wb_sel stays 12.
- Three-way contention, all FUs valid in cycle 0 with rd 5, 9, 33 -> wb_write high in cycles 2, 3, 4 with (sel,tag) = (5,1), (9,2), (33,3); rr_ptr ends at 0.
- Fairness:
  - stimulus: FU0 and FU2 valid every cycle they are ready, for 20 cycles;
  - response: tags alternate 1,3,1,3...;
  - response: neither FU waits more than 2 cycles once non-empty;
  - response: fu_ready toggles correctly at DEPTH=2.
- Full/backpressure:
  - stimulus: FU1 issues 4 back-to-back completions rd 1..4 while FU0 saturates;
  - response: fu_ready[1] drops to 0 when pending[1]=2;
  - response: rd 1..4 emerge in order with tag 2, and none are lost.
- Flush with pending entries: load FU0=2 entries and FU1=1 entry, assert flush for one cycle -> no wb_write for those entries, pending=0 next cycle, fu_ready=0 during the flush cycle, and a new completion after the flush emerges 2 cycles later.
- Async reset mid-stream: drop nRST between clock edges while wb_write=1 -> wb_write=0 and pending=0 immediately without waiting for an edge, and no stale writeback after nRST rises.

Source files
------------

// File: rtl/matrix_wb_arbiter.sv
// Writeback arbiter for the matrix register status table: per-FU completion FIFOs,
// round-robin grant of one completion per cycle, registered writeback outputs.
module matrix_wb_arbiter #(
  parameter int NUM_FU = 3,
  parameter int DEPTH  = 2,
  parameter int REG_W  = 6
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  flush,
  input  logic [NUM_FU-1:0]                     fu_valid,
  input  logic [NUM_FU*REG_W-1:0]               fu_rd,
  output logic [NUM_FU-1:0]                     fu_ready,
  output logic                                  wb_write,
  output logic [REG_W-1:0]                      wb_sel,
  output logic [1:0]                            wb_tag,
  output logic [NUM_FU*($clog2(DEPTH)+1)-1:0]   pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [REG_W-1:0] mem    [NUM_FU][DEPTH];
  logic [PW-1:0]    rd_ptr [NUM_FU];
  logic [PW-1:0]    wr_ptr [NUM_FU];
  logic [CW-1:0]    count  [NUM_FU];
  logic [1:0]       rr_ptr;

  logic             grant_valid;
  logic [1:0]       grant_idx;
  logic [REG_W-1:0] head_rd;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  int               idx;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered occupancy, so a full FIFO being drained still refuses.
  always_comb begin
    fu_ready = '0;
    push     = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] != FULL) && !flush;
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!grant_valid && count[idx] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(idx);
      end
    end
    pop = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = grant_valid && (grant_idx == 2'(i));
    end
    head_rd = mem[grant_idx][rd_ptr[grant_idx]];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr   <= '0;
      wb_write <= 1'b0;
      wb_sel   <= '0;
      wb_tag   <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr   <= '0;
      wb_write <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= next_ptr(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= next_ptr(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
      wb_write <= grant_valid;
      // sel/tag keep the last writeback when idle
      if (grant_valid) begin
        wb_sel <= head_rd;
        wb_tag <= grant_idx + 2'd1;
        rr_ptr <= (grant_idx == 2'(NUM_FU - 1)) ? 2'd0 : grant_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= fu_rd[i*REG_W +: REG_W];
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_pending
    assign pending[g*CW +: CW] = count[g];
  end

endmodule

// File: tb/tb_matrix_wb_arbiter.sv
// Scoreboard bench for matrix_wb_arbiter: a queue-based reference model predicts
// each writeback, and a negedge monitor compares DUT outputs against it.
module tb_matrix_wb_arbiter;

  localparam int NUM_FU = 3;
  localparam int DEPTH  = 2;
  localparam int REG_W  = 6;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic                     CLK = 1'b0;
  logic                     nRST = 1'b0;
  logic                     flush = 1'b0;
  logic [NUM_FU-1:0]        fu_valid = '0;
  logic [NUM_FU*REG_W-1:0]  fu_rd = '0;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     wb_write;
  logic [REG_W-1:0]         wb_sel;
  logic [1:0]               wb_tag;
  logic [NUM_FU*CW-1:0]     pending;

  matrix_wb_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .fu_valid(fu_valid), .fu_rd(fu_rd),
    .fu_ready(fu_ready), .wb_write(wb_write), .wb_sel(wb_sel), .wb_tag(wb_tag),
    .pending(pending)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [REG_W-1:0] sel;
    logic [1:0]       tag;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  logic [REG_W-1:0] fifo_q[NUM_FU][$];
  int               rr = 0;
  int               cyc = 0;
  logic [REG_W-1:0] last_sel = '0;
  logic [1:0]       last_tag = '0;
  int               compared = 0;
  int               mismatched = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: each FU is a plain queue, grants follow a rotating search from rr.
  always @(posedge CLK or negedge nRST) begin : model
    int g;
    int j;
    logic [NUM_FU-1:0] acc;
    exp_t e;
    if (!nRST) begin
      for (int i = 0; i < NUM_FU; i++) fifo_q[i].delete();
      exp_q.delete();
      rr = 0;
      last_sel = '0;
      last_tag = '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) fifo_q[i].delete();
      rr = 0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) acc[i] = fu_valid[i] && (fifo_q[i].size() < DEPTH);
      g = -1;
      for (int k = 0; k < NUM_FU; k++) begin
        j = (rr + k) % NUM_FU;
        if (g < 0 && fifo_q[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        e.sel = fifo_q[g].pop_front();
        e.tag = 2'(g + 1);
        e.due = cyc + 1;
        exp_q.push_back(e);
        rr = (g + 1) % NUM_FU;
      end
      for (int i = 0; i < NUM_FU; i++)
        if (acc[i]) fifo_q[i].push_back(fu_rd[i*REG_W +: REG_W]);
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    for (int i = 0; i < NUM_FU; i++) begin
      check_output($sformatf("pending[%0d]", i), 32'(pending[i*CW +: CW]), 32'(fifo_q[i].size()));
      check_output($sformatf("fu_ready[%0d]", i), 32'(fu_ready[i]),
                   32'((fifo_q[i].size() < DEPTH) && !flush));
      compared++;
      assert (pending[i*CW +: CW] <= DEPTH) else begin
        mismatched++;
        $display("[TB] FAIL occupancy_bound[%0d]: got %0d, required <= %0d", i, pending[i*CW +: CW], DEPTH);
      end
    end
    if (wb_write) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_wb: got sel %0d tag %0d, required no writeback", wb_sel, wb_tag);
      end else begin
        e = exp_q.pop_front();
        check_output("wb_sel", 32'(wb_sel), 32'(e.sel));
        check_output("wb_tag", 32'(wb_tag), 32'(e.tag));
        check_output("wb_cycle", 32'(cyc), 32'(e.due));
        last_sel = e.sel;
        last_tag = e.tag;
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        compared++;
        mismatched++;
        $display("[TB] FAIL missing_wb: got no writeback, required sel %0d tag %0d", e.sel, e.tag);
      end
      check_output("hold_sel", 32'(wb_sel), 32'(last_sel));
      check_output("hold_tag", 32'(wb_tag), 32'(last_tag));
    end
  end

  task automatic apply_stimulus(input logic [2:0] v, input logic [5:0] r0, input logic [5:0] r1,
                                input logic [5:0] r2, input logic f);
    fu_valid = v;
    fu_rd    = {r2, r1, r0};
    flush    = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int  k;
    bit  acc;
    bit  found;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    check_output("reset_wb_write", 32'(wb_write), 32'd0);
    check_output("reset_pending", 32'(pending), 32'd0);
    check_output("reset_fu_ready", 32'(fu_ready), 32'h7);

    $display("[TB] single completion");
    apply_stimulus(3'b001, 6'd12, 6'd0, 6'd0, 1'b0);
    idle(4);

    $display("[TB] three-way contention");
    apply_stimulus(3'b111, 6'd5, 6'd9, 6'd33, 1'b0);
    idle(5);

    $display("[TB] fairness FU0/FU2");
    for (int c = 0; c < 20; c++)
      apply_stimulus({fu_ready[2], 1'b0, fu_ready[0]}, 6'($urandom), 6'd0, 6'($urandom), 1'b0);
    idle(5);

    $display("[TB] backpressure on FU1");
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      acc = fu_ready[1];
      apply_stimulus(3'b011, 6'($urandom), 6'(k + 1), 6'd0, 1'b0);
      if (acc) k++;
    end
    check_output("fu1_accepted", 32'(k), 32'd4);
    idle(8);

    $display("[TB] flush with pending entries");
    apply_stimulus(3'b011, 6'd7, 6'd8, 6'd0, 1'b0);
    apply_stimulus(3'b001, 6'd10, 6'd0, 6'd0, 1'b0);
    apply_stimulus(3'b111, 6'd40, 6'd41, 6'd42, 1'b1);
    apply_stimulus(3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
    apply_stimulus(3'b001, 6'd20, 6'd0, 6'd0, 1'b0);
    idle(4);

    $display("[TB] async reset mid-stream");
    apply_stimulus(3'b011, 6'd17, 6'd18, 6'd0, 1'b0);
    apply_stimulus(3'b000, 6'd0, 6'd0, 6'd0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge CLK);
      #2;
      if (wb_write) found = 1'b1;
    end
    check_output("reset_window_found", 32'(found), 32'd1);
    nRST = 1'b0;
    #1;
    check_output("async_wb_write", 32'(wb_write), 32'd0);
    check_output("async_pending", 32'(pending), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b1;
    idle(5);

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++)
      apply_stimulus(3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
                     ($urandom_range(0, 31) == 0));
    idle(8);
    check_output("drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
